// File: rtl/bp_me_nonsynth_tr_issue_ctrl.sv
// bp_me_nonsynth_tr_issue_ctrl: trace-replay issue controller with outstanding limit and watchdog
module bp_me_nonsynth_tr_issue_ctrl #(
    parameter int tr_ring_width_p   = 128,
    parameter int max_outstanding_p = 4,
    parameter int timeout_cycles_p  = 1024
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic [tr_ring_width_p-1:0] tr_pkt_i,
    input  logic                       tr_pkt_v_i,
    output logic                       tr_pkt_ready_o,
    input  logic                       tr_last_i,
    output logic [tr_ring_width_p-1:0] lce_tr_pkt_o,
    output logic                       lce_tr_pkt_v_o,
    input  logic                       lce_tr_pkt_yumi_i,
    input  logic                       lce_tr_resp_v_i,
    output logic                       lce_tr_resp_ready_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       timeout_o,
    output logic [3:0]                 outstanding_o,
    output logic [31:0]                issued_o,
    output logic [31:0]                retired_o
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERROR} state_e;

    state_e                     state_q, state_d;
    logic                       pkt_v_q, pkt_v_d;
    logic [tr_ring_width_p-1:0] pkt_q, pkt_d;
    logic [3:0]                 outs_q, outs_d;
    logic [31:0]                issued_q, issued_d;
    logic [31:0]                retired_q, retired_d;
    logic [31:0]                wd_q, wd_d;
    logic                       active, yumi_hs, resp_hs, accept;
    logic [3:0]                 outs_eff;

    // Handshakes only count while the matching output is asserted, so ERROR freezes everything.
    assign active              = (state_q == RUN) || (state_q == DRAIN);
    assign lce_tr_pkt_v_o      = active && pkt_v_q;
    assign lce_tr_resp_ready_o = active && (outs_q != 4'd0);
    assign yumi_hs             = lce_tr_pkt_yumi_i && lce_tr_pkt_v_o;
    assign resp_hs             = lce_tr_resp_v_i && lce_tr_resp_ready_o;
    assign outs_eff            = outs_q + {3'b0, yumi_hs} - {3'b0, resp_hs};
    // The packet in flight through the issue register is already counted in outs_eff, so
    // commands in flight never exceed the limit.
    assign tr_pkt_ready_o      = (state_q == RUN) && (!pkt_v_q || yumi_hs)
                                 && (outs_eff < 4'(max_outstanding_p));
    assign accept              = tr_pkt_v_i && tr_pkt_ready_o;
    assign lce_tr_pkt_o        = pkt_q;
    assign busy_o              = active;
    assign done_o              = state_q == DONE;
    assign timeout_o           = state_q == ERROR;
    assign outstanding_o       = outs_q;
    assign issued_o            = issued_q;
    assign retired_o           = retired_q;

    // Next-state, issue register, counters and watchdog.
    always_comb begin
        state_d   = state_q;
        pkt_v_d   = pkt_v_q;
        pkt_d     = pkt_q;
        outs_d    = outs_q;
        issued_d  = issued_q;
        retired_d = retired_q;
        wd_d      = wd_q;
        if ((state_q == IDLE || state_q == DONE) && start_i) begin
            state_d   = RUN;
            pkt_v_d   = 1'b0;
            outs_d    = 4'd0;
            issued_d  = 32'd0;
            retired_d = 32'd0;
            wd_d      = 32'd0;
        end else if (active) begin
            outs_d    = outs_eff;
            issued_d  = issued_q + {31'b0, yumi_hs};
            retired_d = retired_q + {31'b0, resp_hs};
            pkt_v_d   = accept || (pkt_v_q && !yumi_hs);
            pkt_d     = accept ? tr_pkt_i : pkt_q;
            wd_d      = (outs_q != 4'd0 && !resp_hs) ? wd_q + 32'd1 : 32'd0;
            if (wd_d == 32'(timeout_cycles_p))
                state_d = ERROR;
            else if (state_q == RUN && accept && tr_last_i)
                state_d = DRAIN;
            else if (state_q == DRAIN && !pkt_v_d && outs_d == 4'd0)
                state_d = DONE;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            pkt_v_q   <= 1'b0;
            pkt_q     <= '0;
            outs_q    <= 4'd0;
            issued_q  <= 32'd0;
            retired_q <= 32'd0;
            wd_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            pkt_v_q   <= pkt_v_d;
            pkt_q     <= pkt_d;
            outs_q    <= outs_d;
            issued_q  <= issued_d;
            retired_q <= retired_d;
            wd_q      <= wd_d;
        end
    end
endmodule

// File: tb/tb_bp_me_nonsynth_tr_issue_ctrl.sv
// tb_bp_me_nonsynth_tr_issue_ctrl: directed table and sequence checks of the issue controller
module tb_bp_me_nonsynth_tr_issue_ctrl;
    logic         clk_i = 1'b0;
    logic         reset_i, start_i, tr_pkt_v_i, tr_last_i, lce_tr_pkt_yumi_i, lce_tr_resp_v_i;
    logic [127:0] tr_pkt_i;
    logic         tr_pkt_ready_o, lce_tr_pkt_v_o, lce_tr_resp_ready_o, busy_o, done_o, timeout_o;
    logic [127:0] lce_tr_pkt_o;
    logic [3:0]   outstanding_o;
    logic [31:0]  issued_o, retired_o;
    int           checks = 0, failures = 0;

    bp_me_nonsynth_tr_issue_ctrl #(
        .tr_ring_width_p(128), .max_outstanding_p(4), .timeout_cycles_p(16)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .tr_pkt_i(tr_pkt_i), .tr_pkt_v_i(tr_pkt_v_i), .tr_pkt_ready_o(tr_pkt_ready_o),
        .tr_last_i(tr_last_i), .lce_tr_pkt_o(lce_tr_pkt_o), .lce_tr_pkt_v_o(lce_tr_pkt_v_o),
        .lce_tr_pkt_yumi_i(lce_tr_pkt_yumi_i), .lce_tr_resp_v_i(lce_tr_resp_v_i),
        .lce_tr_resp_ready_o(lce_tr_resp_ready_o), .busy_o(busy_o), .done_o(done_o),
        .timeout_o(timeout_o), .outstanding_o(outstanding_o), .issued_o(issued_o),
        .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       start, pv, last, yumi, rv;
        logic [7:0] tag;
        logic       ready, v, rr, busy, done;
        logic [3:0] outs;
        logic [31:0] iss, ret;
        logic [7:0] etag;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic pv, input logic l, input logic [7:0] tg,
                         input logic y, input logic rv);
        @(negedge clk_i);
        start_i = s; tr_pkt_v_i = pv; tr_last_i = l; tr_pkt_i = {16{tg}};
        lce_tr_pkt_yumi_i = y; lce_tr_resp_v_i = rv;
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_hs"}, {tr_pkt_ready_o, lce_tr_pkt_v_o, lce_tr_resp_ready_o, busy_o, done_o, timeout_o}, 6'b0);
        chk({name, "_cnt"}, {outstanding_o, issued_o, retired_o}, 68'b0);
        chk({name, "_pkt"}, lce_tr_pkt_o, 128'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        int acc, n, peak;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 8'hA1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 32'd1, 32'd0, 8'hB2};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 32'd2, 32'd0, 8'hC3};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 32'd3, 32'd1, 8'h00};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'd3, 32'd2, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'd3, 32'd3, 8'h00};

        reset_i = 1'b1; start_i = 0; tr_pkt_v_i = 0; tr_last_i = 0; tr_pkt_i = '0;
        lce_tr_pkt_yumi_i = 0; lce_tr_resp_v_i = 0;
        repeat (2) @(negedge clk_i);
        #1 chk_all_zero("reset_init");
        reset_i = 1'b0;

        // Three-packet run with immediate yumi and responses two cycles after issue.
        peak = 0;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].start, vecs[i].pv, vecs[i].last, vecs[i].tag, vecs[i].yumi, vecs[i].rv);
            chk($sformatf("run3_status_row%0d", i),
                {tr_pkt_ready_o, lce_tr_pkt_v_o, lce_tr_resp_ready_o, busy_o, done_o, outstanding_o},
                {vecs[i].ready, vecs[i].v, vecs[i].rr, vecs[i].busy, vecs[i].done, vecs[i].outs});
            chk($sformatf("run3_issued_row%0d", i), issued_o, vecs[i].iss);
            chk($sformatf("run3_retired_row%0d", i), retired_o, vecs[i].ret);
            if (vecs[i].v) chk($sformatf("run3_pkt_row%0d", i), lce_tr_pkt_o, {16{vecs[i].etag}});
            if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
        end
        chk("run3_peak_outstanding", peak, 2);

        // Outstanding limit with responses withheld.
        drive(1, 0, 0, 8'h00, 0, 0);
        chk("limit_start_from_done", done_o, 1);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            start_i = 0; tr_pkt_v_i = 1; tr_last_i = 0; tr_pkt_i = {16{8'(i + 1)}};
            lce_tr_pkt_yumi_i = lce_tr_pkt_v_o; lce_tr_resp_v_i = 0;
            #1 if (tr_pkt_ready_o) acc++;
        end
        chk("limit_accepts", acc, 4);
        chk("limit_outstanding", outstanding_o, 4);
        chk("limit_ready_low", tr_pkt_ready_o, 0);
        chk("limit_issued", issued_o, 4);
        @(negedge clk_i);
        lce_tr_pkt_yumi_i = lce_tr_pkt_v_o; lce_tr_resp_v_i = 1; tr_pkt_v_i = 1;
        #1 chk("limit_ready_on_resp", tr_pkt_ready_o, 1);
        if (tr_pkt_ready_o) acc++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            lce_tr_pkt_yumi_i = lce_tr_pkt_v_o; lce_tr_resp_v_i = 0; tr_pkt_v_i = 1;
            #1 if (tr_pkt_ready_o) acc++;
        end
        chk("limit_one_more_accept", acc, 5);
        chk("limit_counts", {outstanding_o, issued_o, retired_o}, {4'd4, 32'd5, 32'd1});

        // Asynchronous reset with three commands outstanding.
        drive(0, 0, 0, 8'h00, 0, 1);
        drive(0, 0, 0, 8'h00, 0, 0);
        chk("mid_reset_pre", {busy_o, outstanding_o}, {1'b1, 4'd3});
        #2 reset_i = 1'b1;
        #1 chk_all_zero("mid_reset_async");
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1 chk_all_zero("post_reset_idle");

        // Yumi withheld five cycles, then same-cycle yumi and response.
        drive(1, 0, 0, 8'h00, 0, 0);
        drive(0, 1, 0, 8'h55, 0, 0);
        chk("stall_accept", tr_pkt_ready_o, 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 8'h66, 0, 0);
            chk($sformatf("stall_hold_c%0d", i), {lce_tr_pkt_v_o, tr_pkt_ready_o, lce_tr_pkt_o},
                {1'b1, 1'b0, {16{8'h55}}});
        end
        drive(0, 1, 0, 8'h66, 1, 0);
        chk("stall_release", {tr_pkt_ready_o, issued_o}, {1'b1, 32'd0});
        drive(0, 1, 0, 8'h77, 1, 0);
        chk("b2b_second", {lce_tr_pkt_v_o, tr_pkt_ready_o, outstanding_o, issued_o, lce_tr_pkt_o},
            {1'b1, 1'b1, 4'd1, 32'd1, {16{8'h66}}});
        drive(0, 0, 0, 8'h00, 1, 1);
        chk("same_cycle_pre", {lce_tr_resp_ready_o, outstanding_o, issued_o, retired_o, lce_tr_pkt_o},
            {1'b1, 4'd2, 32'd2, 32'd0, {16{8'h77}}});
        drive(0, 1, 1, 8'h88, 0, 0);
        chk("same_cycle_post", {tr_pkt_ready_o, outstanding_o, issued_o, retired_o},
            {1'b1, 4'd2, 32'd3, 32'd1});
        drive(0, 1, 0, 8'h99, 1, 0);
        chk("drain_issue", {lce_tr_pkt_v_o, tr_pkt_ready_o, busy_o, lce_tr_pkt_o},
            {1'b1, 1'b0, 1'b1, {16{8'h88}}});
        drive(0, 0, 0, 8'h00, 0, 1);
        chk("drain_resp1", {lce_tr_resp_ready_o, outstanding_o}, {1'b1, 4'd3});
        drive(0, 0, 0, 8'h00, 0, 1);
        drive(0, 0, 0, 8'h00, 0, 1);
        chk("drain_resp3", {done_o, outstanding_o}, {1'b0, 4'd1});
        drive(0, 0, 0, 8'h00, 0, 0);
        chk("drain_done", {done_o, busy_o, outstanding_o, issued_o, retired_o},
            {1'b1, 1'b0, 4'd0, 32'd4, 32'd4});

        // Watchdog timeout with one command issued and never answered.
        drive(1, 0, 0, 8'h00, 0, 0);
        drive(0, 1, 0, 8'hA5, 0, 0);
        chk("wd_accept", {tr_pkt_ready_o, issued_o, retired_o}, {1'b1, 32'd0, 32'd0});
        drive(0, 0, 0, 8'h00, 1, 0);
        chk("wd_valid", lce_tr_pkt_v_o, 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 0, 8'h00, 0, 0);
            if (timeout_o) break;
            n++;
        end
        chk("wd_cycles_to_timeout", n, 16);
        drive(1, 1, 0, 8'hAA, 0, 1);
        chk("err_outputs", {tr_pkt_ready_o, lce_tr_pkt_v_o, lce_tr_resp_ready_o, busy_o, done_o, timeout_o},
            6'b000001);
        chk("err_counts", {outstanding_o, issued_o, retired_o}, {4'd1, 32'd1, 32'd0});
        drive(0, 0, 0, 8'h00, 0, 0);
        chk("err_ignores_start", {timeout_o, busy_o, retired_o}, {1'b1, 1'b0, 32'd0});

        @(negedge clk_i);
        reset_i = 1'b1;
        #1 chk_all_zero("err_reset");
        @(negedge clk_i);
        reset_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
